tone_envelope: RTL and testbench
================================

// Module: tone_envelope
// PURPOSE
//   ADSR amplitude envelope for the TinyTone sound path. Sits between the
//   NotesRom/SequenceCounter pair and PwmModulator.
//   - Takes the current note period and a note gate/trigger.
//   - Produces the PWM duty value, scaled by an envelope level, in place of a
//     fixed period>>1. Notes fade in and out instead of clicking on and off.
// PARAMETERS
//   BW           24      width of period_i / dutyCycle_o
//   LW           8       envelope level width; full scale MAX = 2^LW-1
//   TICK_DIV     2400    clk cycles per envelope step (>=2)
//   ATTACK_STEP  8       level increment per tick in ATTACK
//   DECAY_STEP   2       level decrement per tick in DECAY
//   SUSTAIN_LVL  160     sustain level; must satisfy 0 < SUSTAIN_LVL < MAX
//   RELEASE_STEP 4       level decrement per tick in RELEASE
// PORTS
//   clk_i        in   1    clock
//   rst_n_i      in   1    reset, asynchronous, active-low
//   gate_i       in   1    note held (level-sensitive)
//   trig_i       in   1    one-cycle note-start pulse (e.g. sequencer strobe)
//   period_i     in   BW   current note period from NotesRom
//   dutyCycle_o  out  BW   scaled duty cycle to PwmModulator
//   level_o      out  LW   current envelope level
//   state_o      out  3    IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   busy_o       out  1    state_o != IDLE
// BEHAVIOUR
//   Reset (async, rst_n_i=0)
//     - state IDLE, level 0, prescaler 0, dutyCycle_o 0, busy_o 0.
//     - Takes effect immediately; no clock needed, including mid-envelope.
//   Prescaler
//     - Counts 0..TICK_DIV-1 while busy, then wraps.
//     - tick is asserted when count == TICK_DIV-1.
//     - Forced to 0 in IDLE and on an accepted trigger.
//     - If a trigger is accepted at edge E0, the first level step lands at
//       edge E0+TICK_DIV.
//   Trigger accept
//     - A trigger is accepted when trig_i & gate_i.
//     - Accepted from any state: goes to ATTACK next edge.
//     - Level is kept, not zeroed (legato retrigger, no click).
//     - trig_i with gate_i=0 is ignored.
//     - gate_i=1 without trig_i does not leave IDLE.
//   Transitions, all registered. Priority: accepted trig > gate low > tick.
//     - ATTACK: on tick, level = min(level+ATTACK_STEP, MAX). If the new value
//       == MAX, go to DECAY on the same edge.
//     - DECAY: on tick, level = max(level-DECAY_STEP, SUSTAIN_LVL). If the new
//       value == SUSTAIN_LVL, go to SUSTAIN.
//     - SUSTAIN: level held.
//     - From ATTACK, DECAY or SUSTAIN, gate_i=0 goes to RELEASE next edge.
//       No level change that cycle, even if tick is asserted.
//     - RELEASE: on tick, level = max(level-RELEASE_STEP, 0). If the new value
//       == 0, go to IDLE.
//   Arithmetic
//     - Level add/sub is computed at LW+1 bits and saturated; no wrap-around.
//   Duty
//     - dutyCycle_o <= ((period_i>>1) * level_o) >> LW.
//     - Full BW+LW product; bits [BW+LW-1:LW] are taken.
//     - Latency: one clk after level_o or period_i changes.
//     - level 0 gives duty 0, i.e. silent output.
// TESTING  (BW=24, LW=8, TICK_DIV=4, ATTACK=64, DECAY=16, SUSTAIN=128,
//           RELEASE=32, period_i=125)
//   1. Reset: hold rst_n_i=0 ->
//      state_o 0, level_o 0, dutyCycle_o 0, busy_o 0.
//   2. trig+gate pulse, gate held ->
//      - level 64,128,192,255 at 4-cycle spacing, then DECAY.
//      - level 239..128, then SUSTAIN.
//      - dutyCycle_o = 62*128>>8 = 31.
//   3. gate low in SUSTAIN ->
//      - RELEASE next edge.
//      - level 96,64,32,0, then IDLE, busy_o 0, duty 0.
//   4. Retrigger in RELEASE at level 64 ->
//      ATTACK, level 128,192,255; no drop to 0.
//   5. trig with gate_i=0, and gate_i=1 without trig -> stays IDLE.
//   6. rst_n_i low mid-ATTACK between clock edges ->
//      outputs 0 at once; IDLE after release of reset.

Source files
------------

// File: rtl/tone_envelope.sv
// ADSR amplitude envelope: scales the note's half-period duty by an envelope level
// so notes fade in and out instead of clicking on and off.
module tone_envelope #(
   parameter int BW           = 24,
   parameter int LW           = 8,
   parameter int TICK_DIV     = 2400,
   parameter int ATTACK_STEP  = 8,
   parameter int DECAY_STEP   = 2,
   parameter int SUSTAIN_LVL  = 160,
   parameter int RELEASE_STEP = 4
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          gate_i,
   input  logic          trig_i,
   input  logic [BW-1:0] period_i,
   output logic [BW-1:0] dutyCycle_o,
   output logic [LW-1:0] level_o,
   output logic [2:0]    state_o,
   output logic          busy_o
);

   // state   | meaning
   // IDLE    | silent, prescaler held at 0
   // ATTACK  | level rises by ATTACK_STEP per tick up to full scale
   // DECAY   | level falls by DECAY_STEP per tick down to SUSTAIN_LVL
   // SUSTAIN | level held while gate is high
   // RELEASE | level falls by RELEASE_STEP per tick down to 0
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ATTACK  = 3'd1;
   localparam logic [2:0] S_DECAY   = 3'd2;
   localparam logic [2:0] S_SUSTAIN = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;

   localparam int          PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [LW:0] MAX_W     = {1'b0, {LW{1'b1}}};
   localparam logic [LW:0] ATK_W     = (LW+1)'(ATTACK_STEP);
   localparam logic [LW:0] DEC_W     = (LW+1)'(DECAY_STEP);
   localparam logic [LW:0] SUS_W     = (LW+1)'(SUSTAIN_LVL);
   localparam logic [LW:0] REL_W     = (LW+1)'(RELEASE_STEP);

   logic [2:0]    state_q, state_d;
   logic [LW-1:0] level_q, level_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [BW-1:0] duty_q, duty_d;

   logic          tick;
   logic          accept;
   logic [LW:0]   atk_sum;
   logic [LW:0]   dec_diff;
   logic [LW:0]   rel_diff;
   logic [BW+LW-1:0] prod;

   assign tick     = (state_q != S_IDLE) && (presc_q == TICK_LAST);
   assign accept   = trig_i & gate_i;
   assign atk_sum  = {1'b0, level_q} + ATK_W;
   assign dec_diff = {1'b0, level_q} - DEC_W;
   assign rel_diff = {1'b0, level_q} - REL_W;
   assign prod     = (BW+LW)'(period_i >> 1) * (BW+LW)'(level_q);

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      presc_d = presc_q;
      duty_d  = BW'(prod >> LW);

      if (state_q == S_IDLE || tick) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + 1'b1;
      end

      // Retrigger keeps the current level so a legato note does not click.
      if (accept) begin
         state_d = S_ATTACK;
         presc_d = '0;
      end else if (!gate_i && (state_q == S_ATTACK || state_q == S_DECAY ||
                               state_q == S_SUSTAIN)) begin
         state_d = S_RELEASE;
      end else if (tick) begin
         case (state_q)
            S_ATTACK: begin
               if (atk_sum >= MAX_W) begin
                  level_d = LW'(MAX_W);
                  state_d = S_DECAY;
               end else begin
                  level_d = LW'(atk_sum);
               end
            end
            S_DECAY: begin
               // The borrow bit flags an underflow, which also saturates.
               if (dec_diff[LW] || dec_diff <= SUS_W) begin
                  level_d = LW'(SUS_W);
                  state_d = S_SUSTAIN;
               end else begin
                  level_d = LW'(dec_diff);
               end
            end
            S_RELEASE: begin
               if (rel_diff[LW] || rel_diff == '0) begin
                  level_d = '0;
                  state_d = S_IDLE;
               end else begin
                  level_d = LW'(rel_diff);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         level_q <= '0;
         presc_q <= '0;
         duty_q  <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         presc_q <= presc_d;
         duty_q  <= duty_d;
      end
   end

   assign dutyCycle_o = duty_q;
   assign level_o     = level_q;
   assign state_o     = state_q;
   assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_tone_envelope.sv
// Bench for tone_envelope: arithmetic envelope model compared every cycle,
// plus directed scenarios with hand-computed checkpoints.
module tb_tone_envelope;

   localparam int TICK = 4;
   localparam int ATK  = 64;
   localparam int DEC  = 16;
   localparam int SUS  = 128;
   localparam int REL  = 32;
   localparam int FULL = 255;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        gate   = 1'b0;
   logic        trig   = 1'b0;
   logic [23:0] period = 24'd125;
   logic [23:0] duty;
   logic [7:0]  level;
   logic [2:0]  state;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   tone_envelope #(
      .BW(24), .LW(8), .TICK_DIV(TICK), .ATTACK_STEP(ATK), .DECAY_STEP(DEC),
      .SUSTAIN_LVL(SUS), .RELEASE_STEP(REL)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .gate_i(gate), .trig_i(trig),
      .period_i(period), .dutyCycle_o(duty), .level_o(level),
      .state_o(state), .busy_o(busy)
   );

   always #5 clk = ~clk;

   // Model: phase 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
   // steps_left counts edges until the next level step.
   int m_phase = 0;
   int m_level = 0;
   int m_duty  = 0;
   int steps_left = TICK;

   always @(posedge clk or negedge rst_n) begin
      bit step;
      if (!rst_n) begin
         m_phase = 0; m_level = 0; m_duty = 0; steps_left = TICK;
      end else begin
         m_duty = ((int'(period) / 2) * m_level) / 256;
         step = 1'b0;
         if (m_phase == 0) steps_left = TICK;
         else begin
            steps_left = steps_left - 1;
            if (steps_left == 0) begin step = 1'b1; steps_left = TICK; end
         end
         if (trig && gate) begin
            m_phase = 1; steps_left = TICK;
         end else if (!gate && m_phase >= 1 && m_phase <= 3) begin
            m_phase = 4;
         end else if (step) begin
            if (m_phase == 1) begin
               m_level = (m_level + ATK > FULL) ? FULL : m_level + ATK;
               if (m_level == FULL) m_phase = 2;
            end else if (m_phase == 2) begin
               m_level = (m_level - DEC < SUS) ? SUS : m_level - DEC;
               if (m_level == SUS) m_phase = 3;
            end else if (m_phase == 4) begin
               m_level = (m_level - REL < 0) ? 0 : m_level - REL;
               if (m_level == 0) m_phase = 0;
            end
         end
      end
   end

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_state", state, m_phase);
         check("model_level", level, m_level);
         check("model_duty", duty, m_duty);
         check("model_busy", busy, (m_phase != 0));
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_state(input int st, input int budget, input string nm);
      int n = 0;
      while (state !== 3'(st) && n < budget) begin @(negedge clk); n++; end
      check(nm, state, st);
   endtask

   task automatic wait_level(input int lv, input int budget, input string nm);
      int n = 0;
      while (level !== 8'(lv) && n < budget) begin @(negedge clk); n++; end
      check(nm, level, lv);
   endtask

   task automatic pulse_trig();
      trig = 1'b1; gate = 1'b1;
      @(negedge clk);
      trig = 1'b0;
   endtask

   initial begin
      // 1. reset
      #12;
      check("rst_state", state, 0);
      check("rst_level", level, 0);
      check("rst_duty", duty, 0);
      check("rst_busy", busy, 0);
      cmp_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      cycles(2);

      // 2. attack, decay, sustain
      pulse_trig();
      check("atk_enter", state, 1);
      check("atk_level0", level, 0);
      cycles(3);
      check("atk_before_step", level, 0);
      cycles(1);
      check("atk_64", level, 64);
      cycles(4);
      check("atk_128", level, 128);
      cycles(4);
      check("atk_192", level, 192);
      cycles(4);
      check("atk_255", level, 255);
      check("dec_enter", state, 2);
      cycles(4);
      check("dec_239", level, 239);
      wait_state(3, 60, "sus_reach");
      check("sus_level", level, 128);
      cycles(1);
      check("sus_duty", duty, 31);

      // 3. release to idle
      gate = 1'b0;
      @(negedge clk);
      check("rel_enter", state, 4);
      check("rel_hold", level, 128);
      wait_level(96, 10, "rel_96");
      wait_state(0, 40, "rel_idle");
      check("idle_level", level, 0);
      check("idle_busy", busy, 0);
      cycles(1);
      check("idle_duty", duty, 0);

      // 4. retrigger during release at level 64
      pulse_trig();
      wait_state(3, 120, "re_sus");
      gate = 1'b0;
      wait_level(64, 20, "re_at64");
      check("re_in_rel", state, 4);
      pulse_trig();
      check("re_attack", state, 1);
      check("re_keep64", level, 64);
      cycles(4);
      check("re_128", level, 128);
      cycles(4);
      check("re_192", level, 192);
      cycles(4);
      check("re_255", level, 255);
      wait_state(3, 60, "re_sus2");
      gate = 1'b0;
      wait_state(0, 40, "re_idle");

      // 5. ignored trigger / gate without trigger
      trig = 1'b1; gate = 1'b0;
      @(negedge clk);
      trig = 1'b0;
      check("trig_no_gate", state, 0);
      gate = 1'b1;
      cycles(10);
      check("gate_no_trig", state, 0);
      check("gate_no_trig_busy", busy, 0);
      gate = 1'b0;
      cycles(2);

      // 6. async reset mid-attack
      pulse_trig();
      cycles(5);
      check("pre_rst_level", level, 64);
      check("pre_rst_duty", duty, 15);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_state", state, 0);
      check("arst_level", level, 0);
      check("arst_duty", duty, 0);
      check("arst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(3);
      check("post_rst_idle", state, 0);
      gate = 1'b0;
      cycles(2);

      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
